// File: rtl/ycbcr422_to_ycbcr444_if.sv
// Pixel-stream bundle for the 4:2:2 -> 4:4:4 chroma upsampler.
// The master drives the 4:2:2 side and consumes the 4:4:4 side; the slave is the upsampler.
interface ycbcr422_to_ycbcr444_if;
  logic [7:0] i_y_8b;
  logic [7:0] i_c_8b;
  logic       i_h_sync;
  logic       i_v_sync;
  logic       i_data_en;
  logic [7:0] o_y_8b;
  logic [7:0] o_cb_8b;
  logic [7:0] o_cr_8b;
  logic       o_h_sync;
  logic       o_v_sync;
  logic       o_data_en;

  modport master (
    output i_y_8b, i_c_8b, i_h_sync, i_v_sync, i_data_en,
    input  o_y_8b, o_cb_8b, o_cr_8b, o_h_sync, o_v_sync, o_data_en
  );

  modport slave (
    input  i_y_8b, i_c_8b, i_h_sync, i_v_sync, i_data_en,
    output o_y_8b, o_cb_8b, o_cr_8b, o_h_sync, o_v_sync, o_data_en
  );
endinterface

// File: rtl/ycbcr422_to_ycbcr444.sv
// 4:2:2 to 4:4:4 chroma upsampler by pair replication; fixed three-stage pipeline
// keeps luma, chroma, syncs and data enable aligned.
module ycbcr422_to_ycbcr444 #(
  parameter bit         CR_FIRST = 1'b0,
  parameter logic [7:0] BLANK_C  = 8'h80
) (
  input logic                    clk,
  input logic                    rst,
  ycbcr422_to_ycbcr444_if.slave  bus
);

  // Stage 1: registered input plus pixel phase and run-start flag.
  logic [7:0] s1_y_q, s1_y_d;
  logic [7:0] s1_c_q, s1_c_d;
  logic       s1_hs_q, s1_hs_d;
  logic       s1_vs_q, s1_vs_d;
  logic       s1_de_q, s1_de_d;
  logic       s1_ph_q, s1_ph_d;
  logic       s1_start_q, s1_start_d;

  // Stage 2: pixel whose chroma pair is resolved against its stage-1 partner.
  logic [7:0] s2_y_q, s2_y_d;
  logic [7:0] s2_c_q, s2_c_d;
  logic       s2_hs_q, s2_hs_d;
  logic       s2_vs_q, s2_vs_d;
  logic       s2_de_q, s2_de_d;
  logic       s2_ph_q, s2_ph_d;
  logic       s2_start_q, s2_start_d;

  // Second chroma component of the last complete pair in the current run.
  logic [7:0] held_q, held_d;

  // Stage 3: output registers.
  logic [7:0] o_y_q, o_y_d;
  logic [7:0] o_cb_q, o_cb_d;
  logic [7:0] o_cr_q, o_cr_d;
  logic       o_hs_q, o_hs_d;
  logic       o_vs_q, o_vs_d;
  logic       o_de_q, o_de_d;

  logic       phase_cur;
  logic       partner_ok;
  logic [7:0] held_eff;
  logic [7:0] c_first;
  logic [7:0] c_second;

  always_comb begin
    phase_cur  = (bus.i_data_en && !s1_de_q) ? 1'b0 : ~s1_ph_q;

    s1_y_d     = bus.i_y_8b;
    s1_c_d     = bus.i_c_8b;
    s1_hs_d    = bus.i_h_sync;
    s1_vs_d    = bus.i_v_sync;
    s1_de_d    = bus.i_data_en;
    s1_ph_d    = bus.i_data_en ? phase_cur : 1'b0;
    s1_start_d = bus.i_data_en & ~s1_de_q;

    s2_y_d     = s1_y_q;
    s2_c_d     = s1_c_q;
    s2_hs_d    = s1_hs_q;
    s2_vs_d    = s1_vs_q;
    s2_de_d    = s1_de_q;
    s2_ph_d    = s1_ph_q;
    s2_start_d = s1_start_q;
  end

  // An odd pixel in stage 1 is always the partner of the even pixel in stage 2,
  // because an odd phase can never be the first pixel of a run.
  always_comb begin
    partner_ok = s1_de_q & s1_ph_q;
    held_eff   = s2_start_q ? BLANK_C : held_q;
    c_first    = s2_c_q;
    c_second   = partner_ok ? s1_c_q : held_eff;

    held_d = held_q;
    o_y_d  = s2_y_q;
    o_hs_d = s2_hs_q;
    o_vs_d = s2_vs_q;
    o_de_d = s2_de_q;
    o_cb_d = BLANK_C;
    o_cr_d = BLANK_C;

    if (s2_de_q) begin
      if (!s2_ph_q) begin
        held_d = c_second;
        if (CR_FIRST) begin
          o_cr_d = c_first;
          o_cb_d = c_second;
        end else begin
          o_cb_d = c_first;
          o_cr_d = c_second;
        end
      end else begin
        // Odd pixel reuses the pair its even partner just put on the outputs.
        o_cb_d = o_cb_q;
        o_cr_d = o_cr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_y_q     <= 8'h00;
      s1_c_q     <= 8'h00;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_de_q    <= 1'b0;
      s1_ph_q    <= 1'b0;
      s1_start_q <= 1'b0;
      s2_y_q     <= 8'h00;
      s2_c_q     <= 8'h00;
      s2_hs_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
      s2_de_q    <= 1'b0;
      s2_ph_q    <= 1'b0;
      s2_start_q <= 1'b0;
      held_q     <= BLANK_C;
      o_y_q      <= 8'h00;
      o_cb_q     <= BLANK_C;
      o_cr_q     <= BLANK_C;
      o_hs_q     <= 1'b0;
      o_vs_q     <= 1'b0;
      o_de_q     <= 1'b0;
    end else begin
      s1_y_q     <= s1_y_d;
      s1_c_q     <= s1_c_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_de_q    <= s1_de_d;
      s1_ph_q    <= s1_ph_d;
      s1_start_q <= s1_start_d;
      s2_y_q     <= s2_y_d;
      s2_c_q     <= s2_c_d;
      s2_hs_q    <= s2_hs_d;
      s2_vs_q    <= s2_vs_d;
      s2_de_q    <= s2_de_d;
      s2_ph_q    <= s2_ph_d;
      s2_start_q <= s2_start_d;
      held_q     <= held_d;
      o_y_q      <= o_y_d;
      o_cb_q     <= o_cb_d;
      o_cr_q     <= o_cr_d;
      o_hs_q     <= o_hs_d;
      o_vs_q     <= o_vs_d;
      o_de_q     <= o_de_d;
    end
  end

  assign bus.o_y_8b    = o_y_q;
  assign bus.o_cb_8b   = o_cb_q;
  assign bus.o_cr_8b   = o_cr_q;
  assign bus.o_h_sync  = o_hs_q;
  assign bus.o_v_sync  = o_vs_q;
  assign bus.o_data_en = o_de_q;

endmodule

// File: doc/ycbcr422_to_ycbcr444.md
Name: ycbcr422_to_ycbcr444

Overview:
- Chroma upsampler that converts an 8-bit 4:2:2 video stream (Y plus one time-multiplexed chroma sample per pixel) into 4:4:4 (Y, Cb, Cr per pixel).
- Sits directly upstream of the YCbCr444-to-RGB888 converter and drives its i_y_8b/i_cb_8b/i_cr_8b and sync/enable inputs.
- Uses chroma replication: both pixels of a pair get the pair's Cb and Cr.
- Fixed pipeline latency; sync and enable are delayed to stay aligned with the data.

Parameters:
- CR_FIRST, 0: chroma order within a pair. 0 = even pixel carries Cb, odd pixel carries Cr. 1 = even pixel carries Cr, odd pixel carries Cb.
- BLANK_C, 8'h80: chroma value driven on o_cb_8b/o_cr_8b when o_data_en is low, and the default chroma for a missing pair partner.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_y_8b  in  8  luma sample.
- i_c_8b  in  8  chroma sample (Cb or Cr by pixel phase).
- i_h_sync  in  1  horizontal sync, passed through.
- i_v_sync  in  1  vertical sync, passed through.
- i_data_en  in  1  active-pixel qualifier.
- o_y_8b  out  8  luma, delayed.
- o_cb_8b  out  8  reconstructed Cb.
- o_cr_8b  out  8  reconstructed Cr.
- o_h_sync  out  1  i_h_sync delayed by LAT.
- o_v_sync  out  1  i_v_sync delayed by LAT.
- o_data_en  out  1  i_data_en delayed by LAT.

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs 0 except o_cb_8b = o_cr_8b = BLANK_C. Phase bit = 0. Held chroma = BLANK_C. All pipeline registers cleared; a sync or enable in flight is discarded.
- Latency LAT = 3 cycles for every output. An input at posedge t appears on the outputs after posedge t+3.
- Phase tracking:
  - Phase toggles on every cycle with i_data_en = 1.
  - Phase is forced to 0 on the first cycle of each active run (i_data_en rising, sampled).
  - Phase 0 = even pixel; phase 1 = odd pixel.
- Pair assembly (CR_FIRST = 0; swap Cb/Cr when CR_FIRST = 1):
  - Even pixel at t: Cb = i_c(t), Cr = i_c(t+1).
  - Odd pixel at t+1: Cb = i_c(t), Cr = i_c(t+1).
  - Two chroma registers are captured per pair. The output stage selects them, so the even pixel waits for its partner, which is why LAT = 3.
- Odd-length run (even pixel followed by i_data_en = 0):
  - The missing chroma takes the last complete pair's value of that component in the same run.
  - If no complete pair exists in the run, it takes BLANK_C.
  - Held values reset to BLANK_C at the start of each run.
- Blanking: when o_data_en = 0, o_cb_8b = o_cr_8b = BLANK_C and o_y_8b = the delayed i_y_8b, passed unmodified.
- Back-to-back runs: a run starting on the cycle right after another ends (one-cycle gap) resets phase correctly. No chroma from the previous run leaks into the new one.
- A gap inside a run (i_data_en low for ≥1 cycle) ends that run; the next high cycle starts a new run at phase 0.
- Syncs are pure delays and are independent of i_data_en.
- No arithmetic, so there are no overflow paths. All datapaths are 8-bit.
- Reset asserted mid-line: outputs return to reset values on the next cycle. The first post-reset run starts at phase 0.

Test Plan:
- Reset, then drive i_data_en = 1 for 4 pixels with Y = 10,20,30,40 and C = 100(Cb),150(Cr),110(Cb),160(Cr) -> 3 cycles later, 4 outputs: (10,100,150), (20,100,150), (30,110,160), (40,110,160); o_data_en high exactly 4 cycles.
- Odd run of 3 pixels, Y = 1,2,3, C = 50,60,70 -> (1,50,60), (2,50,60), (3,70,60). Single-pixel run Y = 9, C = 33 -> (9,33,0x80).
- CR_FIRST = 1 with C = 150,100 -> both pixels output Cb = 100, Cr = 150.
- Toggle i_h_sync/i_v_sync with arbitrary patterns during blanking -> o_h_sync/o_v_sync replicate them delayed exactly 3 cycles. o_cb_8b/o_cr_8b = 0x80 throughout blanking.
- Two runs separated by a 1-cycle gap, the first of odd length 3 -> the second run's first pixel uses its own Cb and its partner's Cr, with no carry-over.
- Assert rst for 1 cycle mid-run -> next cycle all outputs are at reset values. The subsequent 2-pixel run outputs correct pairs after 3 cycles.
